display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
//
// PURPOSE
//  Time-multiplexing scheduler for the dual seven-segment display.
//  - Owns the shared decoder input and both PNP digit-power selects.
//  - Inserts dead-time blanking between digits to prevent ghosting.
//  - Accepts new digit values through a valid/ready handshake and applies
//    them only at frame boundaries, so a frame never shows mixed old/new digits.
//  - Sits between the switch/adder logic and the seven-segment decoder.
//
// PARAMETERS
//  ON_CYCLES     24000  clk cycles each digit is powered (>=1)
//  BLANK_CYCLES  240    clk cycles both digits are off between digits (>=1)
//  CNT_W         16     phase counter width; must hold max(ON,BLANK)-1
//
// PORTS
//  clk           in   1  system clock (HSOSC-derived); all logic on posedge
//  reset         in   1  synchronous, active-high reset
//  enable        in   1  1 = run scan; 0 = stop at next frame boundary
//  d0_in         in   4  digit 0 value offered for update
//  d1_in         in   4  digit 1 value offered for update
//  update_valid  in   1  d0_in/d1_in valid this cycle
//  update_ready  out  1  controller can accept an update (= ~pending_full)
//  digit_val     out  4  value driven to the seven-segment decoder
//  blank         out  1  1 = segments must be off (idle or dead-time)
//  select0       out  1  digit 0 PNP drive, active-low (0 = powered)
//  select1       out  1  digit 1 PNP drive, active-low (0 = powered)
//  frame_tick    out  1  one-cycle pulse on the last cycle of each frame
//
// BEHAVIOUR
//  - Reset values:
//    - state=IDLE, cnt=0, pending_full=0.
//    - pending and shadow registers = 0.
//    - digit_val=0, blank=1, select0=select1=1, frame_tick=0, update_ready=1.
//  - Reset mid-operation: state forced to IDLE on that edge.
//    - Both selects are 1 on the next edge.
//    - Any pending update is discarded.
//  - FSM states: IDLE -> ON0 -> GAP0 -> ON1 -> GAP1 -> (ON0 | IDLE).
//    - IDLE->ON0 on the edge where enable=1 is sampled.
//    - ON* lasts ON_CYCLES and GAP* lasts BLANK_CYCLES.
//    - cnt counts 0..N-1; the state advances and cnt clears when cnt==N-1.
//    - GAP1 exit goes to ON0 if enable=1, else to IDLE.
//    - enable is sampled only in IDLE and on the last GAP1 cycle, so a
//      mid-frame deassert still completes the frame.
//  - Frame length = 2*(ON_CYCLES+BLANK_CYCLES) cycles.
//    - frame_tick=1 only on the last GAP1 cycle.
//  - Outputs are registered and update on the same edge the state is entered:
//    - select0=0 only in ON0; select1=0 only in ON1.
//    - Both selects must never be 0 in the same cycle.
//    - blank=1 in IDLE, GAP0 and GAP1.
//    - digit_val = shadow0 in ON0, shadow1 in ON1; it holds its last value otherwise.
//  - Update handshake:
//    - Transfer occurs when update_valid & update_ready; it loads the pending
//      registers and sets pending_full.
//    - While pending_full=1, update_ready=0 and valid is stalled.
//      The source must hold its data until accepted.
//  - Shadow load:
//    - Happens on the edge that enters ON0 (from IDLE or GAP1).
//    - If pending_full=1: shadow <= pending and pending_full is cleared.
//      update_ready returns to 1 on the following cycle.
//    - A transfer accepted on that same edge goes to pending, not shadow,
//      and is shown from the next frame.
//  - Digit values are 4-bit unsigned (0-F) and pass through unmodified.
//
// TESTING  (bench uses ON_CYCLES=4, BLANK_CYCLES=2; frame = 12 cycles)
//  1. Hold reset 3 cycles
//     -> select0=select1=1, blank=1, digit_val=0, update_ready=1, frame_tick=0.
//  2. Update d0=3, d1=9, then enable=1
//     -> ON0: 4 cycles, select0=0, digit_val=3.
//     -> GAP0: 2 cycles, both selects 1, blank=1.
//     -> ON1: 4 cycles, select1=0, digit_val=9.
//     -> GAP1: 2 cycles; frame_tick on cycle 12.
//  3. Update d0=5, d1=A during cycle 2 of ON0
//     -> frame finishes showing 3/9; next frame shows 5/A.
//     -> update_ready=0 from acceptance until the shadow load.
//  4. Two back-to-back updates (7/1, then 2/2)
//     -> second update stalls with ready=0 until the frame boundary.
//     -> frames show 7/1, then 2/2.
//  5. Drop enable mid ON1
//     -> current frame completes, then IDLE: selects 1, blank=1, no more frame_tick.
//  6. Assert reset during ON1 with an update pending
//     -> next edge: selects 1, blank=1, ready=1.
//     -> after restart, shadow shows 0/0.
//     -> assert select0|select1 is never 0 in every cycle of every test.

Source files
------------

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes two seven-segment digits over one shared decoder input.
// Sequence per frame: ON0 -> GAP0 -> ON1 -> GAP1, with dead-time blanking in
// the gaps. New digit values arrive through a valid/ready handshake, wait in
// a pending register, and are copied to the displayed (shadow) registers only
// when a frame starts, so one frame never mixes old and new digits.

module display_scan_controller #(
  parameter int ON_CYCLES    = 24000,
  parameter int BLANK_CYCLES = 240,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] d0_in,
  input  logic [3:0] d1_in,
  input  logic       update_valid,
  output logic       update_ready,
  output logic [3:0] digit_val,
  output logic       blank,
  output logic       select0,
  output logic       select1,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON0,
    S_GAP0,
    S_ON1,
    S_GAP1
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  logic             pending_full;
  logic [3:0]       pending0;
  logic [3:0]       pending1;
  logic [3:0]       shadow0;
  logic [3:0]       shadow1;

  logic             accept;
  logic             enter_on0;
  logic             enter_on1;

  logic [3:0]       digit_val_d;
  logic             blank_d;
  logic             select0_d;
  logic             select1_d;
  logic             frame_tick_d;

  // A pending slot that is full blocks further transfers until a frame starts.
  assign update_ready = ~pending_full;
  assign accept       = update_valid & ~pending_full;
  assign enter_on0    = (state_d == S_ON0) && (state != S_ON0);
  assign enter_on1    = (state_d == S_ON1) && (state != S_ON1);

  // Phase sequencer: advance state and clear cnt on the last cycle of a phase.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = S_ON0;
      end
      S_ON0: begin
        if (cnt == ON_LAST) begin
          state_d = S_GAP0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_GAP0: begin
        if (cnt == BLANK_LAST) begin
          state_d = S_ON1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_ON1: begin
        if (cnt == ON_LAST) begin
          state_d = S_GAP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_GAP1: begin
        // enable is only honoured here and in IDLE, so a frame always completes.
        if (cnt == BLANK_LAST) begin
          state_d = enable ? S_ON0 : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next output values, derived from the state being entered so the registered
  // outputs change on the same edge as the state.
  always_comb begin
    select0_d    = (state_d != S_ON0);
    select1_d    = (state_d != S_ON1);
    blank_d      = (state_d != S_ON0) && (state_d != S_ON1);
    frame_tick_d = (state_d == S_GAP1) && (cnt_d == BLANK_LAST);
    digit_val_d  = digit_val;
    if (enter_on0) begin
      // The shadow load happens on this same edge, so bypass the pending value.
      digit_val_d = pending_full ? pending0 : shadow0;
    end else if (enter_on1) begin
      digit_val_d = shadow1;
    end
  end

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Update handshake and frame-boundary shadow load.
  always_ff @(posedge clk) begin
    // NOTE: the digit holding registers are reset too, because a reset must
    // discard a pending update and make the next frame show 0/0.
    if (reset) begin
      pending_full <= 1'b0;
      pending0     <= '0;
      pending1     <= '0;
      shadow0      <= '0;
      shadow1      <= '0;
    end else begin
      // accept needs an empty slot and the load needs a full one, so they never collide.
      if (accept) begin
        pending0     <= d0_in;
        pending1     <= d1_in;
        pending_full <= 1'b1;
      end else if (enter_on0 && pending_full) begin
        shadow0      <= pending0;
        shadow1      <= pending1;
        pending_full <= 1'b0;
      end
    end
  end

  // Registered display drive outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_val  <= '0;
      blank      <= 1'b1;
      select0    <= 1'b1;
      select1    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      digit_val  <= digit_val_d;
      blank      <= blank_d;
      select0    <= select0_d;
      select1    <= select1_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
// Directed stimulus pushes the digit pair each completed frame should show;
// a negedge monitor measures every frame and compares it at frame_tick.

module tb_display_scan_controller;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
  } frame_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] d0_in;
  logic [3:0] d1_in;
  logic       update_valid;
  logic       update_ready;
  logic [3:0] digit_val;
  logic       blank;
  logic       select0;
  logic       select1;
  logic       frame_tick;

  int checks;
  int errors;

  frame_t exp_q[$];

  // Monitor state.
  logic       in_frame;
  logic       prev_sel0;
  int         len;
  int         on0;
  int         on1;
  int         gap;
  logic [3:0] d0_seen;
  logic [3:0] d1_seen;
  logic       d0_bad;
  logic       d1_bad;
  frame_t     exp_f;

  display_scan_controller #(
    .ON_CYCLES   (4),
    .BLANK_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .d0_in       (d0_in),
    .d1_in       (d1_in),
    .update_valid(update_valid),
    .update_ready(update_ready),
    .digit_val   (digit_val),
    .blank       (blank),
    .select0     (select0),
    .select1     (select1),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: measure each frame from its first ON0 cycle to frame_tick.
  always @(negedge clk) begin
    if (reset) begin
      in_frame  = 1'b0;
      prev_sel0 = 1'b1;
    end else begin
      check("never_both_selected", 32'(select0 | select1), 32'd1);
      if (select0 == 1'b0 && prev_sel0 == 1'b1) begin
        in_frame = 1'b1;
        len = 0; on0 = 0; on1 = 0; gap = 0;
        d0_bad = 1'b0; d1_bad = 1'b0;
      end
      if (in_frame) begin
        len++;
        if (select0 == 1'b0 && blank == 1'b0) begin
          if (on0 == 0) d0_seen = digit_val;
          else if (digit_val != d0_seen) d0_bad = 1'b1;
          on0++;
        end
        if (select1 == 1'b0 && blank == 1'b0) begin
          if (on1 == 0) d1_seen = digit_val;
          else if (digit_val != d1_seen) d1_bad = 1'b1;
          on1++;
        end
        if (select0 && select1 && blank) gap++;
      end
      if (frame_tick) begin
        if (!in_frame) begin
          checks++; errors++;
          $display("FAIL frame_tick_outside_frame: got tick expected none (t=%0t)", $time);
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got frame %0h/%0h expected no frame (t=%0t)",
                   d0_seen, d1_seen, $time);
        end else begin
          exp_f = exp_q.pop_front();
          check("frame_d0", 32'(d0_seen), 32'(exp_f.d0));
          check("frame_d1", 32'(d1_seen), 32'(exp_f.d1));
          check("frame_d0_steady", 32'(d0_bad), 32'd0);
          check("frame_d1_steady", 32'(d1_bad), 32'd0);
          check("frame_on0_cycles", 32'(on0), 32'd4);
          check("frame_on1_cycles", 32'(on1), 32'd4);
          check("frame_gap_cycles", 32'(gap), 32'd4);
          check("frame_length", 32'(len), 32'd12);
        end
        in_frame = 1'b0;
      end
      prev_sel0 = select0;
    end
  end

  // Wait until a cycle that carries frame_tick; stops #1 after that edge.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_tick && n < 100);
    if (!frame_tick) begin
      checks++; errors++;
      $display("FAIL wait_tick_timeout: got no frame_tick expected one within 100 cycles");
    end
  endtask

  // Offer one update and hold it until accepted; reports cycles stalled.
  task automatic send(input logic [3:0] a, input logic [3:0] b, output int waited);
    update_valid = 1'b1;
    d0_in        = a;
    d1_in        = b;
    waited       = 0;
    while (!update_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!update_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready=0 expected ready within 100 cycles");
    end
    @(posedge clk); #1;
    update_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    checks = 0; errors = 0;
    reset = 1'b1; enable = 1'b0; update_valid = 1'b0; d0_in = '0; d1_in = '0;

    // 1. Reset state.
    step(3);
    check("rst_select0", 32'(select0), 32'd1);
    check("rst_select1", 32'(select1), 32'd1);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_digit_val", 32'(digit_val), 32'd0);
    check("rst_update_ready", 32'(update_ready), 32'd1);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    reset = 1'b0;
    step(1);
    check("idle_selects", 32'({select0, select1, blank}), 32'b111);

    // 2. Load 3/9 while idle, then start scanning.
    send(4'h3, 4'h9, w);
    check("ready_low_after_accept", 32'(update_ready), 32'd0);
    exp_q.push_back('{d0: 4'h3, d1: 4'h9});
    exp_q.push_back('{d0: 4'h3, d1: 4'h9});
    enable = 1'b1;
    step(1);
    check("on0_entered", 32'({select0, select1, blank}), 32'b010);
    check("on0_digit", 32'(digit_val), 32'h3);
    check("ready_after_load", 32'(update_ready), 32'd1);
    wait_tick();

    // 3. Update 5/A during ON0 cycle 2; shown only from the next frame.
    step(2);
    send(4'h5, 4'hA, w);
    check("ready_low_mid_frame", 32'(update_ready), 32'd0);
    exp_q.push_back('{d0: 4'h5, d1: 4'hA});
    wait_tick();
    check("ready_low_until_boundary", 32'(update_ready), 32'd0);
    step(1);
    check("ready_back_after_load", 32'(update_ready), 32'd1);
    check("new_frame_digit", 32'(digit_val), 32'h5);

    // 4. Back-to-back updates: the second stalls until the next frame boundary.
    send(4'h7, 4'h1, w);
    send(4'h2, 4'h2, w);
    check("second_update_stall", 32'(w), 32'd11);
    exp_q.push_back('{d0: 4'h7, d1: 4'h1});
    exp_q.push_back('{d0: 4'h2, d1: 4'h2});
    wait_tick();

    // 5. Drop enable in ON1 cycle 2; the frame completes, then idle.
    step(8);
    check("mid_on1_select1", 32'(select1), 32'd0);
    check("mid_on1_digit", 32'(digit_val), 32'h2);
    enable = 1'b0;
    wait_tick();
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_after_stop", 32'({select0, select1, blank, frame_tick}), 32'b1110);
    end
    check("idle_digit_hold", 32'(digit_val), 32'h2);

    // 6. Reset during ON1 with an update pending.
    enable = 1'b1;
    step(1);
    check("restart_on0", 32'(select0), 32'd0);
    check("restart_digit", 32'(digit_val), 32'h2);
    send(4'h8, 4'h8, w);
    step(6);
    check("pre_reset_on1", 32'(select1), 32'd0);
    check("pre_reset_pending", 32'(update_ready), 32'd0);
    reset = 1'b1;
    step(1);
    check("mid_reset_outputs", 32'({select0, select1, blank, frame_tick}), 32'b1110);
    check("mid_reset_ready", 32'(update_ready), 32'd1);
    check("mid_reset_digit", 32'(digit_val), 32'd0);
    reset = 1'b0;
    exp_q.push_back('{d0: 4'h0, d1: 4'h0});
    step(1);
    check("post_reset_on0", 32'(select0), 32'd0);
    check("post_reset_digit", 32'(digit_val), 32'h0);
    check("post_reset_ready", 32'(update_ready), 32'd1);
    wait_tick();
    enable = 1'b0;
    step(5);
    check("post_reset_idle", 32'({select0, select1, blank}), 32'b111);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
